seq_mul: RTL and testbench
==========================

# seq_mul

Parametrised sequential shift-and-add multiplier, the successor to the repeated-addition multiplier datapath/controller pair. It is a drop-in arithmetic unit for datapaths that need a full-width product with a start/busy/done handshake. Latency is fixed at WIDTH cycles, independent of operand values. Signed two's-complement operation is available as a compile-time option.

## Interface
- WIDTH, 16, operand width in bits; legal range 2..32.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a multiply; sampled on the rising edge of clk.
- a  in  WIDTH  multiplicand; sampled only on the accepting edge.
- b  in  WIDTH  multiplier; sampled only on the accepting edge.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse; indicates that product has just been updated.
- product  out  2*WIDTH  result of the last completed multiply; held until the next completion.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- **Accepting a start:** a start is accepted when start=1 on an edge where the state is IDLE or DONE.
  - On the accepting edge the block latches a into mcand (2*WIDTH bits, zero-extended) and b into mplier (WIDTH bits).
  - It clears acc (2*WIDTH bits), sets cnt=0 and moves to RUN.
- **RUN:** each edge performs one step.
  - If mplier[0]=1, then acc <= acc + mcand.
  - Then mcand <= mcand<<1, mplier <= mplier>>1 and cnt <= cnt+1.
  - On the edge where cnt=WIDTH-1, the final step's sum is written directly into product and the state moves to DONE.
- **DONE:** lasts one cycle.
  - If start=1, a new operation is accepted. Otherwise the state returns to IDLE.
- **Ignored starts:** start is ignored while in RUN. Inputs a and b are not re-sampled.
- **Arithmetic:** the 2*WIDTH accumulator cannot overflow in unsigned mode. There is no saturation and no truncation.
- **Output decode:**
  - busy = (state==RUN).
  - done = (state==DONE).
  - Both are registered state decodes, not combinational from inputs.
- **Reset:** rst=1 at any edge, including mid-RUN, forces the following values and discards any operation in flight. No done is produced for an aborted operation.
  - state=IDLE
  - busy=0
  - done=0
  - product=0
  - acc, mcand, mplier and cnt cleared to 0
- **Reset priority:** rst takes priority over start on the same edge.

## Timing
- Let edge E0 be the edge that accepts start.
- busy goes high after E0 and stays high for exactly WIDTH cycles (edges E1..E(WIDTH)).
- Edge E(WIDTH) loads product, drops busy and raises done.
- done is high for exactly one cycle, between E(WIDTH) and E(WIDTH+1).
- Start-to-done latency is WIDTH cycles. The minimum issue interval is WIDTH+1 cycles, achieved by asserting start during the done cycle.
- product changes only at completion edges and at reset. It is stable during RUN.
- After reset release, the first start can be accepted on the next edge.

## Configuration
- **SEQ_MUL_SIGNED_EN defined:** a and b are two's-complement.
  - On the accepting edge the block stores |a| and |b| as WIDTH-bit unsigned magnitudes; the most negative value maps to 2^(WIDTH-1).
  - It also stores neg = a[WIDTH-1]^b[WIDTH-1].
  - At completion, product = neg ? -(magnitude result) : magnitude result, computed in 2*WIDTH bits.
  - Latency and handshake are unchanged.
  - (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2) is representable and must be exact.
- **SEQ_MUL_SIGNED_EN undefined:** all operands are unsigned and there is no sign logic.

## Test plan
- WIDTH=16, unsigned: a=3, b=5, start for one cycle -> busy for 16 cycles; done pulse 16 cycles after the accepting edge; product=32'h0000000F, held thereafter.
- WIDTH=16, unsigned: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001. Also a=0, b=16'h1234 -> product=0 with identical latency.
- Start pulsed again at cycle 5 of RUN with different a/b -> ignored; the original product is delivered at cycle 16 and there is exactly one done pulse.
- Start held high with a new pair during the done cycle -> second operation accepted; its done arrives 17 cycles after the first done. rst asserted mid-RUN -> busy=0, done never pulses, product=0.
- SEQ_MUL_SIGNED_EN, WIDTH=16: a=-3, b=7 -> product=32'hFFFFFFEB. a=16'h8000, b=16'h8000 -> product=32'h40000000.
- WIDTH=8, unsigned: a=8'hFF, b=8'h02 -> product=16'h01FE; done 8 cycles after the accepting edge.

Source files
------------

// File: rtl/seq_mul_if.sv
// seq_mul_if: start/busy/done handshake plus operand and product buses
// for the seq_mul sequential multiplier. The master drives a request and
// the slave (the multiplier) returns status and the full-width product.
interface seq_mul_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/seq_mul.sv
// seq_mul: shift-and-add multiplier with a fixed latency of WIDTH cycles.
// One partial product is folded into the accumulator per RUN cycle; the
// last step's sum is written straight into the product register, so done
// rises on the same edge that updates the product.
// Optional feature: define SEQ_MUL_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied and the sign is re-applied at completion).
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  seq_mul_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_product;
  logic              r_busy;
  logic              r_done;

  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [PW-1:0]     w_sum;
  logic [PW-1:0]     w_result;
  logic              w_last;

  // Accumulator plus the current partial product (mcand gated by mplier LSB).
  assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});
  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef SEQ_MUL_SIGNED_EN
  logic              r_neg;

  // The most negative operand negates to itself, which read as unsigned is
  // exactly 2^(WIDTH-1), so no extra magnitude bit is needed.
  assign w_mag_a  = bus.a[WIDTH-1] ? ((~bus.a) + WIDTH'(1)) : bus.a;
  assign w_mag_b  = bus.b[WIDTH-1] ? ((~bus.b) + WIDTH'(1)) : bus.b;
  assign w_result = r_neg ? ((~w_sum) + PW'(1)) : w_sum;

  // Sign of the result, captured once per accepted operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (bus.start && (r_state != RUN)) begin
      r_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end
`else
  assign w_mag_a  = bus.a;
  assign w_mag_b  = bus.b;
  assign w_result = w_sum;
`endif

  // Controller and datapath: accept in IDLE/DONE, one shift-add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end else begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
          end
        end
        RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_result;
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: randomized and directed checks of seq_mul against an
// arithmetic reference model (plain integer multiplication).
module tb_seq_mul;

  localparam int W  = 16;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] last_prod = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_if #(.WIDTH(W))  u  ();
  seq_mul_if #(.WIDTH(W8)) u8 ();

  seq_mul #(.WIDTH(W))  dut  (.clk(clk), .rst(rst), .bus(u));
  seq_mul #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(u8));

  // Watchdog: a stuck run must still report and stop.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference product in 2*w bits straight from integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y, input int w);
    longint     sx;
    longint     sy;
    logic [63:0] p;
    sx = longint'(x);
    sy = longint'(y);
`ifdef SEQ_MUL_SIGNED_EN
    if (x[w-1]) sx = sx - (longint'(1) <<< w);
    if (y[w-1]) sy = sy - (longint'(1) <<< w);
`endif
    p = 64'(sx * sy);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Issue one multiply from a negedge; returns at the negedge inside the done cycle.
  task automatic mul_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_at, output int done_cyc);
    logic [63:0] exp;
    int          busy_n;
    int          lat;
    int          unstable;
    exp      = ref_mul(64'(a), 64'(b), W);
    busy_n   = 0;
    lat      = -1;
    unstable = 0;
    u.start = 1'b1;
    u.a     = a;
    u.b     = b;
    @(posedge clk);
    @(negedge clk);
    u.start = 1'b0;
    for (int k = 0; k <= W + 3; k++) begin
      if (u.busy) busy_n++;
      if (u.done) begin
        lat = k;
        break;
      end
      if (64'(u.product) !== last_prod) unstable++;
      if (k == poke_at) begin
        u.start = 1'b1;
        u.a     = W'($urandom);
        u.b     = W'($urandom);
      end
      @(negedge clk);
      u.start = 1'b0;
    end
    check_eq("latency", 64'(lat), 64'(W));
    check_eq("busy_cycles", 64'(busy_n), 64'(W));
    check_eq("product_stable_in_run", 64'(unstable), 64'd0);
    check_eq("product", 64'(u.product), exp);
    $display("op a=%h b=%h poke=%0d -> product=%h (model %h) latency=%0d",
             a, b, poke_at, u.product, exp, lat);
    last_prod = exp;
    done_cyc  = cyc;
  endtask

  // One cycle after a done with no new start: single pulse, idle, product held.
  task automatic idle_check();
    @(negedge clk);
    check_eq("done_single_pulse", 64'(u.done), 64'd0);
    check_eq("idle_busy", 64'(u.busy), 64'd0);
    check_eq("product_held", 64'(u.product), last_prod);
  endtask

  initial begin
    int          d1;
    int          d2;
    int          poke;
    int          lat8;
    int          done_seen;
    bit          chain;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    u.start = 1'b0; u.a = '0; u.b = '0;
    u8.start = 1'b0; u8.a = '0; u8.b = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 64'(u.busy), 64'd0);
    check_eq("reset_done", 64'(u.done), 64'd0);
    check_eq("reset_product", 64'(u.product), 64'd0);
    rst = 1'b0;

    // Directed operands; start is accepted on the first edge after release.
    mul_op(16'd3, 16'd5, -1, d1);
    check_eq("dir_3x5", 64'(u.product), 64'h0000000F);
    idle_check();
    idle_check();
`ifdef SEQ_MUL_SIGNED_EN
    mul_op(16'hFFFD, 16'd7, -1, d1);
    check_eq("dir_m3x7", 64'(u.product), 64'hFFFFFFEB);
    idle_check();
    mul_op(16'h8000, 16'h8000, -1, d1);
    check_eq("dir_min_x_min", 64'(u.product), 64'h40000000);
    idle_check();
`else
    mul_op(16'hFFFF, 16'hFFFF, -1, d1);
    check_eq("dir_max_x_max", 64'(u.product), 64'hFFFE0001);
    idle_check();
`endif
    mul_op(16'h0000, 16'h1234, -1, d1);
    check_eq("dir_zero", 64'(u.product), 64'd0);
    idle_check();

    // Start pulsed in RUN with different operands must be ignored.
    mul_op(16'h0123, 16'h0456, 5, d1);
    idle_check();

    // Back-to-back: new start during the done cycle.
    mul_op(16'h00AB, 16'h00CD, -1, d1);
    mul_op(16'h7FFF, 16'h8001, -1, d2);
    check_eq("chain_done_gap", 64'(d2 - d1), 64'(W + 1));
    idle_check();

    // Randomized mix of idle gaps, chained starts and ignored starts.
    chain = 1'b0;
    d1    = 0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0:       begin ra = '0;            rb = W'($urandom); end
        1:       begin ra = {W{1'b1}};     rb = W'($urandom); end
        2:       begin ra = {1'b1, {(W-1){1'b0}}}; rb = {1'b1, {(W-1){1'b0}}}; end
        default: begin ra = W'($urandom);  rb = W'($urandom); end
      endcase
      poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W - 3)) : -1;
      mul_op(ra, rb, poke, d2);
      if (chain) check_eq("rand_chain_gap", 64'(d2 - d1), 64'(W + 1));
      d1    = d2;
      chain = ($urandom_range(0, 1) == 1);
      if (!chain) idle_check();
    end
    if (chain) idle_check();

    // Reset in the middle of RUN discards the operation.
    u.start = 1'b1; u.a = 16'h1111; u.b = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    u.start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_abort_busy", 64'(u.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 64'(u.busy), 64'd0);
    check_eq("abort_done", 64'(u.done), 64'd0);
    check_eq("abort_product", 64'(u.product), 64'd0);
    rst = 1'b0;
    last_prod = '0;
    done_seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (u.done) done_seen++;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    check_eq("abort_product_held", 64'(u.product), 64'd0);
    mul_op(16'h0042, 16'h0101, -1, d1);
    idle_check();

    // Narrow instance: WIDTH=8.
    u8.start = 1'b1; u8.a = 8'hFF; u8.b = 8'h02;
    @(posedge clk);
    @(negedge clk);
    u8.start = 1'b0;
    lat8 = -1;
    for (int k = 0; k <= W8 + 3; k++) begin
      if (u8.done) begin
        lat8 = k;
        break;
      end
      @(negedge clk);
    end
    check_eq("w8_latency", 64'(lat8), 64'(W8));
    check_eq("w8_product", 64'(u8.product), ref_mul(64'hFF, 64'h02, W8));
    $display("op8 a=ff b=02 -> product=%h latency=%0d", u8.product, lat8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
